trigger_ctrl: RTL and testbench

- Conditions the raw trigger button into the clean `fire` and `error` strobes that the shot counter consumes. The counter's `fire` input is a clock edge, so `fire` must be glitch-free.
- Pipeline: two-flop synchronise, debounce, rising-edge detect, then a fire/cooldown FSM.
- A press during cooldown is a misfire. It raises `error` for a fixed hold time and produces no `fire`.
- Sits between the top-level button input and the counter/display path.

---
 rtl/trigger_ctrl.sv | 140 ++++++++++++++
 tb/tb_trigger_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: turns a raw, bouncy trigger button into clean shot strobes.
// The chain is a two-flop synchroniser, a debouncer, a rising-edge detector,
// and a fire/cooldown FSM that also owns the misfire error hold.
// `fire` drives the shot counter's clock input, so it comes straight from a
// flop and can never glitch.
module trigger_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int ERR_CYCLES      = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic trig_raw,
  output logic fire,
  output logic error,
  output logic busy,
  output logic trig_db
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int ERR_W = (ERR_CYCLES > 1)      ? $clog2(ERR_CYCLES)      : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_t;

  logic             r_s1, r_s2;
  logic             r_db, r_db_d;
  logic [DB_W-1:0]  r_db_cnt;
  state_t           r_state;
  logic [CD_W-1:0]  r_cd_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_fire, r_busy, r_err;

  logic w_press, w_misfire;

  // One-cycle pulse on a debounced press; any press during cooldown is a misfire.
  assign w_press   = r_db & ~r_db_d;
  assign w_misfire = w_press & (r_state == COOLDOWN);

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= trig_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any bounce back restarts the wait. Press and release alike.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_s2 != r_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_db     <= ~r_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Delayed debounced level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_db_d <= 1'b0;
    else        r_db_d <= r_db;
  end

  // Fire/cooldown FSM with registered fire/busy and the misfire error hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cd_cnt  <= '0;
      r_fire    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_fire <= 1'b0;
      case (r_state)
        IDLE: begin
          // A disarmed press or a press under an active error hold is dropped.
          if (w_press && enable && !r_err) begin
            r_state <= FIRE;
            r_fire  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        FIRE: begin
          r_state  <= COOLDOWN;
          r_cd_cnt <= '0;
        end
        COOLDOWN: begin
          // Runs to completion regardless of enable or misfires.
          if (r_cd_cnt == CD_LAST) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_cd_cnt <= '0;
          end else begin
            r_cd_cnt <= r_cd_cnt + CD_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A misfire (re)starts the hold, taking priority over its terminal count.
      if (w_misfire) begin
        r_err     <= 1'b1;
        r_err_cnt <= '0;
      end else if (r_err) begin
        if (r_err_cnt == ERR_LAST) begin
          r_err     <= 1'b0;
          r_err_cnt <= '0;
        end else begin
          r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign fire    = r_fire;
  assign busy    = r_busy;
  assign error   = r_err;
  assign trig_db = r_db;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Bench for trigger_ctrl with short debounce/cooldown/error times. A
// behavioural model (sample history window plus "cycles left" countdowns)
// runs alongside the DUT and is compared every cycle; directed scenarios add
// absolute timing and pulse-count checks.
module tb_trigger_ctrl;
  localparam int D = 4;
  localparam int C = 10;
  localparam int E = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic trig_raw = 1'b0;
  logic fire, error, busy, trig_db;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_ctrl #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C), .ERR_CYCLES(E)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trig_raw(trig_raw),
    .fire(fire), .error(error), .busy(busy), .trig_db(trig_db)
  );

  always #5 clk = ~clk;

  // Reference model. m_cd counts cycles of shot activity left
  // (C+1 = the fire cycle, 1..C = cooldown); m_err counts error-hold cycles left.
  bit   m_s1, m_s2, m_db, m_dbp, mp, mflip;
  bit   hist[$];
  int   m_cd, m_err, n_cd, n_err;
  logic [3:0] m_out;
  assign m_out = {(m_cd == C + 1), (m_err > 0), (m_cd > 0), m_db};

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_cd = 0; m_err = 0;
      hist.delete();
    end else begin
      mp = m_db && !m_dbp;
      // The level flips once the last D synchronised samples all disagree with it.
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      mflip = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_db) mflip = 0;
      if (mp && m_cd >= 1 && m_cd <= C) n_err = E;
      else if (m_err > 0)               n_err = m_err - 1;
      else                              n_err = 0;
      if (m_cd > 0)                           n_cd = m_cd - 1;
      else if (mp && enable && m_err == 0)    n_cd = C + 1;
      else                                    n_cd = 0;
      m_err = n_err;
      m_cd  = n_cd;
      m_dbp = m_db;
      if (mflip) begin m_db = !m_db; hist.delete(); end
      m_s2 = m_s1;
      m_s1 = trig_raw;
    end
  end

  task automatic test_reset();
    reset = 0; enable = 1; trig_raw = 1;
    repeat (8) begin
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_hold: f/e/b/db=%b exp 0000", {fire, error, busy, trig_db});
      end
    end
    trig_raw = 0; reset = 1;
    repeat (6) @(negedge clk);
    trig_raw = 1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk); n_tests++;
      if (fire !== (k == 6) || busy !== (k >= 6 && k <= 16) || error !== 1'b0) begin
        n_fail++; $display("FAIL reset_latency k=%0d: f/b/e=%b%b%b exp %b%b0", k, fire, busy, error, k == 6, k >= 6 && k <= 16);
      end
      n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_reset t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
    end
    trig_raw = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    int nf = 0, ne = 0, nr = 0;
    logic prev = trig_db;
    enable = 1;
    for (int i = 0; i < 80; i++) begin
      trig_raw = (i < 20) ? ((i / 2) % 2 == 0) : (i < 60);
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_bounce t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
      nf += int'(fire); ne += int'(error); nr += int'(trig_db && !prev); prev = trig_db;
    end
    n_tests++;
    if (nf != 1 || nr != 1 || ne != 0) begin
      n_fail++; $display("FAIL bounce_counts: fires=%0d db_rises=%0d err_cycles=%0d exp 1/1/0", nf, nr, ne);
    end
  endtask

  // Shot, release, re-press during cooldown. rel_on_fire=0 releases as soon as
  // the debounced level rises (re-press lands mid-cooldown); 1 releases at the
  // fire pulse (re-press lands on the final cooldown cycle).
  task automatic misfire_run(input bit rel_on_fire);
    int nf = 0, ne = 0, nb = 0, t0 = -1;
    trig_raw = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_misfire%0d t=%0t: f/e/b/db=%b exp %b", rel_on_fire, $time, {fire, error, busy, trig_db}, m_out);
      end
      nf += int'(fire); ne += int'(error); nb += int'(busy);
      if (t0 < 0 && (rel_on_fire ? fire : trig_db)) t0 = i;
      if (t0 >= 0) trig_raw = !(i >= t0 && i < t0 + 4);
    end
    n_tests++;
    if (nf != 1 || ne != E || nb != C + 1) begin
      n_fail++; $display("FAIL misfire%0d_counts: fires=%0d err_cycles=%0d busy_cycles=%0d exp 1/%0d/%0d", rel_on_fire, nf, ne, nb, E, C + 1);
    end
    trig_raw = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_misfire();
    enable = 1;
    misfire_run(1'b0);
    misfire_run(1'b1);
  endtask

  task automatic test_disarmed();
    int nf = 0, nx = 0;
    enable = 0; trig_raw = 1;
    for (int i = 0; i < 72; i++) begin
      if (i == 20) enable = 1;
      if (i == 40) trig_raw = 0;
      if (i == 52) trig_raw = 1;
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_disarmed t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
      if (i < 40) nx += int'(fire) + int'(error) + int'(busy);
      else        nf += int'(fire);
    end
    n_tests++;
    if (nx != 0 || nf != 1) begin
      n_fail++; $display("FAIL disarmed_counts: activity_while_held=%0d fires_after_repress=%0d exp 0/1", nx, nf);
    end
    trig_raw = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    enable = 1; trig_raw = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = fire;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL reset_mid_fire: no fire within 20 cycles exp 1"); end
    repeat (2) @(negedge clk);
    reset = 0; #1; n_tests++;
    if ({fire, error, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_cooldown: f/e/b=%b exp 000", {fire, error, busy});
    end
    @(negedge clk); trig_raw = 0; reset = 1;
    repeat (6) @(negedge clk);
    trig_raw = 1;
    // Normal latency again, with a release/re-press that misfires on the last
    // cooldown cycle so the error hold is active when reset hits.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n_tests++;
      if (fire !== (k == 6) || busy !== (k >= 6 && k <= 16) || (k == 19 && error !== 1'b1)) begin
        n_fail++; $display("FAIL reset_mid_latency k=%0d: f/b/e=%b%b%b", k, fire, busy, error);
      end
      n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_reset_mid t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
      trig_raw = !(k >= 6 && k < 10);
    end
    reset = 0; #1; n_tests++;
    if ({fire, error, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_error: f/e/b=%b exp 000", {fire, error, busy});
    end
    @(negedge clk); trig_raw = 0; reset = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_held();
    int nf1 = 0, nf2 = 0, ne = 0;
    enable = 1;
    for (int i = 0; i < 100; i++) begin
      trig_raw = (i < 50) || (i >= 65);
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_held t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
      if (i < 50) nf1 += int'(fire); else nf2 += int'(fire);
      ne += int'(error);
    end
    n_tests++;
    if (nf1 != 1 || nf2 != 1 || ne != 0) begin
      n_fail++; $display("FAIL held_counts: held_fires=%0d repress_fires=%0d err_cycles=%0d exp 1/1/0", nf1, nf2, ne);
    end
    trig_raw = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        run = $urandom_range(1, 12);
        trig_raw = ~trig_raw;
        if ($urandom_range(0, 3) == 0) enable = $urandom_range(0, 3) != 0;
      end
      run--;
      @(negedge clk); n_tests++;
      if ({fire, error, busy, trig_db} !== m_out) begin
        n_fail++; $display("FAIL model_random t=%0t: f/e/b/db=%b exp %b", $time, {fire, error, busy, trig_db}, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_misfire();
    test_disarmed();
    test_reset_mid();
    test_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
